// File: rtl/multi_mod_cnt.sv
// multi_mod_cnt: counter that steps through a sequence of NPHASE moduli.
// Each phase p counts 0..M(p)-1, where M(p) = max(1, mod_cfg slice p), then
// advances to the next phase. Ending phase NPHASE-1 returns to phase 0.
// wrap pulses after any phase ends; seq_done pulses after the last phase ends.
// Priority of the synchronous controls is clr > ld > en.
// Optional feature: define MULTI_MOD_CNT_SEQCNT_EN to add a completed-sequence
// counter (parameter SEQ_W, output seq_cnt).
module multi_mod_cnt #(
   parameter int WIDTH  = 3,
   parameter int NPHASE = 2,
`ifdef MULTI_MOD_CNT_SEQCNT_EN
   parameter int SEQ_W  = 8,
`endif
   localparam int PW    = (NPHASE > 1) ? $clog2(NPHASE) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      ld,
   input  logic [PW-1:0]             ld_phase,
   input  logic [WIDTH-1:0]          ld_val,
   input  logic [NPHASE*WIDTH-1:0]   mod_cfg,
`ifdef MULTI_MOD_CNT_SEQCNT_EN
   output logic [SEQ_W-1:0]          seq_cnt,
`endif
   output logic [WIDTH-1:0]          cnt,
   output logic [PW-1:0]             phase,
   output logic                      wrap,
   output logic                      seq_done
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
   logic [SEQ_W-1:0] seq_q, seq_d;
`endif

   logic [WIDTH-1:0] mod_cur;
   logic [WIDTH-1:0] term_lim;
   logic             term;
   logic             last_ph;
   logic             ld_ok;

   // Pick the live modulus of the current phase (mux over valid phases only).
   always_comb begin
      mod_cur = '0;
      for (int p = 0; p < NPHASE; p++) begin
         if (phase_q == PW'(p)) mod_cur = mod_cfg[p*WIDTH +: WIDTH];
      end
   end

   // Terminal when count reaches M-1; ">=" also catches a modulus lowered
   // below the current count or an out-of-range loaded value.
   always_comb begin
      term_lim = (mod_cur == '0) ? '0 : mod_cur - WIDTH'(1);
      term     = (cnt_q >= term_lim);
      last_ph  = (phase_q == PW'(NPHASE - 1));
      ld_ok    = ({1'b0, ld_phase} < (PW+1)'(NPHASE));
   end

   // Next-state selection: clr beats ld beats en; pulses only on enabled terminal steps.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      seq_d   = seq_q;
`endif
      if (clr) begin
         cnt_d   = '0;
         phase_d = '0;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
         seq_d   = '0;
`endif
      end else if (ld) begin
         phase_d = ld_ok ? ld_phase : '0;
         cnt_d   = ld_val;
      end else if (en) begin
         if (term) begin
            cnt_d   = '0;
            phase_d = last_ph ? '0 : phase_q + PW'(1);
            wrap_d  = 1'b1;
            done_d  = last_ph;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
            if (last_ph) seq_d = seq_q + SEQ_W'(1);
`endif
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= '0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
         seq_q   <= '0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
         seq_q   <= seq_d;
`endif
      end
   end

   assign cnt      = cnt_q;
   assign phase    = phase_q;
   assign wrap     = wrap_q;
   assign seq_done = done_q;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
   assign seq_cnt  = seq_q;
`endif

endmodule

// File: tb/tb_multi_mod_cnt.sv
// tb_multi_mod_cnt: three instances (NPHASE=2, 4, 1) sharing controls.
// An integer model of the counting rules is compared every negedge, and
// literal sequences pin the model for the key scenarios.
module tb_multi_mod_cnt;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0, clr = 1'b0, ld = 1'b0;
   logic        ld_ph = 1'b0;
   logic [1:0]  ld_ph4 = 2'd0;
   logic [2:0]  ld_val = 3'd0;
   logic [5:0]  mod2;
   logic [11:0] mod4;
   logic [2:0]  mod1;

   logic [2:0] u2_cnt, u4_cnt, u1_cnt;
   logic       u2_ph, u1_ph;
   logic [1:0] u4_ph;
   logic       u2_wrap, u2_done, u4_wrap, u4_done, u1_wrap, u1_done;
`ifdef MULTI_MOD_CNT_SEQCNT_EN
   logic [7:0] u2_seq, u4_seq, u1_seq;
`endif

   int n_chk = 0;
   int n_err = 0;

   logic [4:0] exp2_q[$];
   logic [6:0] exp4_q[$];

   int m_cnt[3] = '{0, 0, 0};
   int m_ph[3]  = '{0, 0, 0};
   bit m_w[3]   = '{0, 0, 0};
   bit m_d[3]   = '{0, 0, 0};
   int m_seq    = 0;

   // clock
   always #5 clk = ~clk;

   multi_mod_cnt #(.WIDTH(3), .NPHASE(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_phase(ld_ph),
      .ld_val(ld_val), .mod_cfg(mod2),
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      .seq_cnt(u2_seq),
`endif
      .cnt(u2_cnt), .phase(u2_ph), .wrap(u2_wrap), .seq_done(u2_done));

   multi_mod_cnt #(.WIDTH(3), .NPHASE(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_phase(ld_ph4),
      .ld_val(ld_val), .mod_cfg(mod4),
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      .seq_cnt(u4_seq),
`endif
      .cnt(u4_cnt), .phase(u4_ph), .wrap(u4_wrap), .seq_done(u4_done));

   multi_mod_cnt #(.WIDTH(3), .NPHASE(1)) u1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .ld_phase(ld_ph),
      .ld_val(ld_val), .mod_cfg(mod1),
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      .seq_cnt(u1_seq),
`endif
      .cnt(u1_cnt), .phase(u1_ph), .wrap(u1_wrap), .seq_done(u1_done));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- model ----------------
   function automatic int nph_of(input int k);
      return (k == 0) ? 2 : (k == 1) ? 4 : 1;
   endfunction

   function automatic logic [11:0] cfg_of(input int k);
      return (k == 0) ? {6'b0, mod2} : (k == 1) ? mod4 : {9'b0, mod1};
   endfunction

   function automatic int eff_mod(input logic [11:0] cfg, input int p);
      int m;
      m = int'(cfg[p*3 +: 3]);
      return (m == 0) ? 1 : m;
   endfunction

   function automatic int lph_of(input int k);
      return (k == 1) ? int'(ld_ph4) : int'(ld_ph);
   endfunction

   // Model: apply the counting rules to integer state on every clock.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) begin
            m_cnt[k] <= 0; m_ph[k] <= 0; m_w[k] <= 1'b0; m_d[k] <= 1'b0;
         end
         m_seq <= 0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_w[k] <= 1'b0;
            m_d[k] <= 1'b0;
            if (clr) begin
               m_cnt[k] <= 0;
               m_ph[k]  <= 0;
               if (k == 0) m_seq <= 0;
            end else if (ld) begin
               m_ph[k]  <= (lph_of(k) >= nph_of(k)) ? 0 : lph_of(k);
               m_cnt[k] <= int'(ld_val);
            end else if (en) begin
               if (m_cnt[k] >= eff_mod(cfg_of(k), m_ph[k]) - 1) begin
                  m_cnt[k] <= 0;
                  m_ph[k]  <= (m_ph[k] + 1) % nph_of(k);
                  m_w[k]   <= 1'b1;
                  m_d[k]   <= (m_ph[k] == nph_of(k) - 1);
                  if (k == 0 && m_ph[k] == 1) m_seq <= (m_seq + 1) % 256;
               end else begin
                  m_cnt[k] <= m_cnt[k] + 1;
               end
            end
         end
      end
   end

   // Compare DUTs with the model and literal queues every negedge.
   always @(negedge clk) begin
      logic [4:0] e2;
      logic [6:0] e4;
      chk("u2_cnt",  32'(u2_cnt),  m_cnt[0]);
      chk("u2_ph",   32'(u2_ph),   m_ph[0]);
      chk("u2_wrap", 32'(u2_wrap), 32'(m_w[0]));
      chk("u2_done", 32'(u2_done), 32'(m_d[0]));
      chk("u4_cnt",  32'(u4_cnt),  m_cnt[1]);
      chk("u4_ph",   32'(u4_ph),   m_ph[1]);
      chk("u4_wrap", 32'(u4_wrap), 32'(m_w[1]));
      chk("u4_done", 32'(u4_done), 32'(m_d[1]));
      chk("u1_cnt",  32'(u1_cnt),  m_cnt[2]);
      chk("u1_ph",   32'(u1_ph),   m_ph[2]);
      chk("u1_wrap", 32'(u1_wrap), 32'(m_w[2]));
      chk("u1_done", 32'(u1_done), 32'(m_d[2]));
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      chk("u2_seq",  32'(u2_seq),  m_seq);
`endif
      if (exp2_q.size() > 0) begin
         e2 = exp2_q.pop_front();
         chk("lit_u2", 32'({u2_done, u2_wrap, u2_cnt}), 32'(e2));
      end
      if (exp4_q.size() > 0) begin
         e4 = exp4_q.pop_front();
         chk("lit_u4", 32'({u4_done, u4_wrap, u4_ph, u4_cnt}), 32'(e4));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int l2c[16] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 0, 1, 1, 1, 2};
      int l4c[9]  = '{0, 1, 0, 1, 2, 0, 0, 0, 1};
      int l4p[9]  = '{0, 0, 1, 1, 1, 2, 3, 0, 0};
      mod2 = {3'd6, 3'd5};
      mod4 = {3'd0, 3'd1, 3'd3, 3'd2};
      mod1 = 3'd5;

      // reset state
      @(negedge clk);
      chk("rst_cnt",  32'(u2_cnt),  0);
      chk("rst_wrap", 32'(u2_wrap), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // sequence {6,5} and {0,1,3,2}, then en 1,0,0,1
      for (int i = 0; i < 16; i++)
         exp2_q.push_back({(i == 11), (i == 5 || i == 11), 3'(l2c[i])});
      for (int i = 0; i < 9; i++)
         exp4_q.push_back({(i == 7), (i == 2 || i == 5 || i == 6 || i == 7), 2'(l4p[i]), 3'(l4c[i])});
      en = 1'b1;
      repeat (11) cyc();
      en = 1'b1; cyc();
      en = 1'b0; cyc();
      cyc();
      en = 1'b1; cyc();
      en = 1'b0;
      @(negedge clk);

      // live modulus reduction below the current count in phase 1
      cyc();
      ld = 1'b1; ld_ph = 1'b1; ld_ph4 = 2'd2; ld_val = 3'd4;
      cyc();
      ld = 1'b0; mod2 = {3'd3, 3'd5}; en = 1'b1;
      cyc();
      @(negedge clk);
      chk("modchg_cnt",  32'(u2_cnt),  0);
      chk("modchg_ph",   32'(u2_ph),   0);
      chk("modchg_wrap", 32'(u2_wrap), 1);
      chk("modchg_done", 32'(u2_done), 1);
      chk("n1_wrap",     32'(u1_wrap), 1);
      chk("n1_done",     32'(u1_done), 1);
      chk("u4_ph3",      32'(u4_ph),   3);

      // clr + ld together, then out-of-range load
      mod2 = {3'd6, 3'd5};
      cyc(); cyc(); cyc();
      clr = 1'b1; ld = 1'b1; ld_ph = 1'b1; ld_ph4 = 2'd3; ld_val = 3'd5;
      cyc();
      @(negedge clk);
      chk("clrld_cnt",  32'(u2_cnt),  0);
      chk("clrld_ph",   32'(u2_ph),   0);
      chk("clrld_wrap", 32'(u2_wrap), 0);
      cyc();
      clr = 1'b0; ld = 1'b1; ld_ph = 1'b1; ld_val = 3'd7;
      cyc();
      @(negedge clk);
      chk("ld7_cnt", 32'(u2_cnt), 7);
      chk("ld7_ph",  32'(u2_ph),  1);
      cyc();
      ld = 1'b0;
      cyc();
      @(negedge clk);
      chk("oor_cnt",  32'(u2_cnt),  0);
      chk("oor_ph",   32'(u2_ph),   0);
      chk("oor_wrap", 32'(u2_wrap), 1);
      chk("oor_done", 32'(u2_done), 1);

      // async reset in phase 1 at count 3
      cyc();
      en = 1'b0; ld = 1'b1; ld_ph = 1'b1; ld_val = 3'd3;
      cyc();
      ld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cnt", 32'(u2_cnt), 0);
      chk("arst_ph",  32'(u2_ph),  0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // moduli 0,0: one sequence per two steps; 256 sequences wrap seq_cnt
      mod2 = 6'd0; en = 1'b1;
      repeat (510) cyc();
      @(negedge clk);
      chk("s255_done", 32'(u2_done), 1);
      chk("s255_ph",   32'(u2_ph),   0);
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      chk("s255_seq",  32'(u2_seq),  255);
`endif
      cyc(); cyc();
      @(negedge clk);
      chk("s256_done", 32'(u2_done), 1);
`ifdef MULTI_MOD_CNT_SEQCNT_EN
      chk("s256_seq",  32'(u2_seq),  0);
`endif
      en = 1'b0;
      chk("q2_drain", 32'(exp2_q.size()), 0);
      chk("q4_drain", 32'(exp4_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
